// File: rtl/mem_stage.sv
// MEM pipeline stage: valid/ready handshake on both sides, multi-cycle data-memory
// access with alignment check, and branch-resolution outputs.
module mem_stage #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned LAT   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        InValid,
    output logic        InReady,
    input  logic [31:0] InAddRes,
    input  logic        InZeroFlag,
    input  logic [31:0] InAluRes,
    input  logic [31:0] InDatoLec2,
    input  logic        InMemRead,
    input  logic        InMemWrite,
    input  logic        InBranch,
    input  logic        InRegWrite,
    input  logic        InMemToReg,
    input  logic [4:0]  InWriteReg,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] DatoMemOut,
    output logic [31:0] AluResOut,
    output logic        RegWriteOut,
    output logic        MemToRegOut,
    output logic [4:0]  WriteRegOut,
    output logic        PCSrcOut,
    output logic [31:0] BranchTargetOut,
    output logic        AlignErrOut
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idxQ;
    logic [31:0]   storeQ;
    logic          readQ;
    logic          writeQ;

    logic xfer;
    logic isMem;
    logic misal;

    // Ready in IDLE, or in HOLD when the held entry retires this same cycle.
    assign InReady = (state == IDLE) || ((state == HOLD) && OutReady);
    assign xfer    = InValid && InReady;
    assign isMem   = InMemRead || InMemWrite;
    assign misal   = isMem && (InAluRes[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            idxQ            <= '0;
            storeQ          <= '0;
            readQ           <= 1'b0;
            writeQ          <= 1'b0;
            OutValid        <= 1'b0;
            DatoMemOut      <= '0;
            AluResOut       <= '0;
            RegWriteOut     <= 1'b0;
            MemToRegOut     <= 1'b0;
            WriteRegOut     <= '0;
            PCSrcOut        <= 1'b0;
            BranchTargetOut <= '0;
            AlignErrOut     <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            PCSrcOut <= 1'b0;
            case (state)
                IDLE, HOLD: begin
                    if (xfer) begin
                        AluResOut       <= InAluRes;
                        BranchTargetOut <= InAddRes;
                        WriteRegOut     <= InWriteReg;
                        MemToRegOut     <= InMemToReg;
                        RegWriteOut     <= InRegWrite && !misal;
                        AlignErrOut     <= misal;
                        PCSrcOut        <= InBranch && InZeroFlag;
                        DatoMemOut      <= '0;
                        idxQ            <= InAluRes[AW+1:2];
                        storeQ          <= InDatoLec2;
                        readQ           <= InMemRead;
                        writeQ          <= InMemWrite;
                        if (isMem && !misal) begin
                            state    <= BUSY;
                            cnt      <= CW'(LAT - 1);
                            OutValid <= 1'b0;
                        end else begin
                            state    <= HOLD;
                            OutValid <= 1'b1;
                        end
                    end else if ((state == HOLD) && OutReady) begin
                        state    <= IDLE;
                        OutValid <= 1'b0;
                    end
                end
                BUSY: begin
                    // Read sees the pre-write word when a read and a write coincide.
                    if (cnt == '0) begin
                        if (writeQ) begin
                            mem[idxQ] <= storeQ;
                        end
                        if (readQ) begin
                            DatoMemOut <= mem[idxQ];
                        end
                        state    <= HOLD;
                        OutValid <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized transactions
// compared against a word-array reference model.
module tb_mem_stage;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        InValid;
    logic        InReady;
    logic [31:0] InAddRes;
    logic        InZeroFlag;
    logic [31:0] InAluRes;
    logic [31:0] InDatoLec2;
    logic        InMemRead, InMemWrite, InBranch, InRegWrite, InMemToReg;
    logic [4:0]  InWriteReg;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] DatoMemOut, AluResOut, BranchTargetOut;
    logic        RegWriteOut, MemToRegOut, PCSrcOut, AlignErrOut;
    logic [4:0]  WriteRegOut;

    typedef struct packed {
        logic mr, mw, br, zf, rw, m2r;
        logic [4:0]  wr;
        logic [31:0] alu, data, tgt;
    } txn_t;

    typedef struct packed {
        logic [7:0]  lat;
        logic [7:0]  pcsCount;
        logic        pcsFirst;
        logic        validAfter;
        logic [31:0] dato, alu, tgt;
        logic        rw, m2r, aerr;
        logic [4:0]  wr;
    } obs_t;

    logic [31:0] refMem [DEPTH];
    int checks = 0;
    int errors = 0;

    mem_stage #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .InValid(InValid), .InReady(InReady),
        .InAddRes(InAddRes), .InZeroFlag(InZeroFlag), .InAluRes(InAluRes),
        .InDatoLec2(InDatoLec2), .InMemRead(InMemRead), .InMemWrite(InMemWrite),
        .InBranch(InBranch), .InRegWrite(InRegWrite), .InMemToReg(InMemToReg),
        .InWriteReg(InWriteReg), .OutValid(OutValid), .OutReady(OutReady),
        .DatoMemOut(DatoMemOut), .AluResOut(AluResOut), .RegWriteOut(RegWriteOut),
        .MemToRegOut(MemToRegOut), .WriteRegOut(WriteRegOut), .PCSrcOut(PCSrcOut),
        .BranchTargetOut(BranchTargetOut), .AlignErrOut(AlignErrOut)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic txn_t mk(input logic mr, mw, br, zf, rw, m2r, input logic [4:0] wr,
                                input logic [31:0] alu, data, tgt);
        txn_t t;
        t.mr = mr; t.mw = mw; t.br = br; t.zf = zf; t.rw = rw; t.m2r = m2r;
        t.wr = wr; t.alu = alu; t.data = data; t.tgt = tgt;
        return t;
    endfunction

    function automatic obs_t sampleObs();
        obs_t o;
        o = '0;
        o.dato = DatoMemOut; o.alu = AluResOut; o.tgt = BranchTargetOut;
        o.rw = RegWriteOut; o.m2r = MemToRegOut; o.aerr = AlignErrOut; o.wr = WriteRegOut;
        return o;
    endfunction

    // Reference: word array indexed by (addr/4) mod DEPTH, latency LAT+1 for aligned memory ops.
    task automatic modelTxn(input txn_t t, output obs_t e);
        logic isMem, mis;
        int unsigned idx;
        isMem = t.mr || t.mw;
        mis   = isMem && ((t.alu % 4) != 0);
        idx   = (t.alu / 4) % DEPTH;
        e = '0;
        e.lat      = (isMem && !mis) ? 8'(LAT + 1) : 8'd1;
        e.pcsFirst = t.br && t.zf;
        e.pcsCount = (t.br && t.zf) ? 8'd1 : 8'd0;
        e.dato     = (t.mr && !mis) ? refMem[idx] : 32'd0;
        if (t.mw && !mis) refMem[idx] = t.data;
        e.alu = t.alu; e.tgt = t.tgt; e.rw = t.rw && !mis; e.m2r = t.m2r;
        e.aerr = mis; e.wr = t.wr;
    endtask

    task automatic driveIn(input txn_t t);
        InMemRead = t.mr; InMemWrite = t.mw; InBranch = t.br; InZeroFlag = t.zf;
        InRegWrite = t.rw; InMemToReg = t.m2r; InWriteReg = t.wr;
        InAluRes = t.alu; InDatoLec2 = t.data; InAddRes = t.tgt;
    endtask

    task automatic scrambleIn();
        InValid = 1'b0;
        driveIn(mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 5'($urandom), $urandom, $urandom, $urandom));
    endtask

    // Drives one transaction with OutReady high and records what the outputs did.
    task automatic runTxn(input txn_t t, output obs_t o);
        int n, w, pcs;
        logic first;
        @(negedge clk);
        driveIn(t);
        InValid = 1'b1;
        w = 0;
        while (!InReady && w < 20) begin @(negedge clk); w++; end
        @(negedge clk);
        scrambleIn();
        n = 1;
        first = PCSrcOut;
        pcs = int'(PCSrcOut);
        while (!OutValid && n < 20) begin @(negedge clk); n++; pcs += int'(PCSrcOut); end
        o = sampleObs();
        o.lat = 8'(n);
        o.pcsFirst = first;
        @(negedge clk);
        pcs += int'(PCSrcOut);
        o.pcsCount = 8'(pcs);
        o.validAfter = OutValid;
    endtask

    task automatic test_reset();
        logic [105:0] allOut;
        rst_n = 1'b0; OutReady = 1'b1; scrambleIn();
        for (int i = 0; i < int'(DEPTH); i++) refMem[i] = 32'd0;
        repeat (3) @(negedge clk);
        allOut = {OutValid, DatoMemOut, AluResOut, RegWriteOut, MemToRegOut, WriteRegOut,
                  PCSrcOut, BranchTargetOut, AlignErrOut};
        checks++;
        if (allOut !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", allOut);
        end
        checks++;
        if (InReady !== 1'b1) begin
            errors++; $display("FAIL reset_inready: got %b want 1", InReady);
        end
        rst_n = 1'b1;
    endtask

    task automatic runList(input string name, input txn_t v[$]);
        obs_t o, e;
        foreach (v[i]) begin
            modelTxn(v[i], e);
            runTxn(v[i], o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s[%0d]: got/want lat %0d/%0d dato %h/%h aerr %b/%b regwr %b/%b pcs %0d/%0d tgt %h/%h (obs %h want %h)",
                         name, i, o.lat, e.lat, o.dato, e.dato, o.aerr, e.aerr, o.rw, e.rw,
                         o.pcsCount, e.pcsCount, o.tgt, e.tgt, o, e);
            end
        end
    endtask

    task automatic test_store_load();
        txn_t v[$];
        v.push_back(mk(0, 1, 0, 0, 0, 0, 5'd0, 32'h10, 32'hDEADBEEF, 32'h0));
        v.push_back(mk(1, 0, 0, 0, 1, 1, 5'd3, 32'h10, $urandom, 32'h4));
        runList("store_load", v);
    endtask

    task automatic test_branch();
        txn_t v[$];
        v.push_back(mk(0, 0, 1, 1, 1, 0, 5'd7, $urandom, $urandom, 32'h40));
        v.push_back(mk(0, 0, 1, 0, 1, 0, 5'd8, $urandom, $urandom, 32'h44));
        v.push_back(mk(1, 0, 1, 1, 1, 1, 5'd9, 32'h10, $urandom, 32'h48));
        runList("branch", v);
    endtask

    task automatic test_misaligned();
        txn_t v[$];
        v.push_back(mk(0, 1, 0, 0, 1, 0, 5'd4, 32'h13, 32'h55AA55AA, 32'h0));
        v.push_back(mk(1, 0, 0, 0, 1, 1, 5'd5, 32'h10, $urandom, 32'h0));
        v.push_back(mk(1, 0, 0, 0, 1, 1, 5'd6, 32'h11, $urandom, 32'h0));
        runList("misaligned", v);
    endtask

    task automatic test_read_write_same();
        txn_t v[$];
        v.push_back(mk(0, 1, 0, 0, 0, 0, 5'd0, 32'h8, 32'hA5A5_0001, 32'h0));
        v.push_back(mk(1, 1, 0, 0, 1, 1, 5'd1, 32'h8, 32'h5A5A_0002, 32'h0));
        v.push_back(mk(1, 0, 0, 0, 1, 1, 5'd2, 32'h8, $urandom, 32'h0));
        runList("rw_same", v);
    endtask

    task automatic test_wrap();
        txn_t v[$];
        v.push_back(mk(0, 1, 0, 0, 0, 0, 5'd0, 32'h100, 32'h1234, 32'h0));
        v.push_back(mk(1, 0, 0, 0, 1, 1, 5'd11, 32'h000, $urandom, 32'h0));
        runList("wrap", v);
    endtask

    task automatic test_back_to_back();
        txn_t a, b;
        obs_t eA, eB, s;
        int w;
        a = mk(0, 0, 1, 1, 1, 1, 5'd9, $urandom, $urandom, 32'h80);
        b = mk(0, 0, 0, 0, 1, 0, 5'd10, $urandom, $urandom, 32'hC0);
        modelTxn(a, eA); modelTxn(b, eB);
        eA.lat = '0; eA.pcsCount = '0; eA.pcsFirst = 1'b0; eA.validAfter = 1'b0;
        eB.lat = '0; eB.pcsCount = '0; eB.pcsFirst = 1'b0; eB.validAfter = 1'b0;
        @(negedge clk);
        OutReady = 1'b0;
        driveIn(a); InValid = 1'b1;
        w = 0;
        while (!InReady && w < 20) begin @(negedge clk); w++; end
        @(negedge clk);
        driveIn(b); InValid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            s = sampleObs();
            checks++;
            if (s !== eA || OutValid !== 1'b1 || InReady !== 1'b0 || PCSrcOut !== 1'(k == 0)) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: got valid %b ready %b pcs %b obs %h want valid 1 ready 0 pcs %b obs %h",
                         k, OutValid, InReady, PCSrcOut, s, 1'(k == 0), eA);
            end
            @(negedge clk);
        end
        OutReady = 1'b1;
        #1;
        checks++;
        if (InReady !== 1'b1) begin
            errors++; $display("FAIL backpressure_release_ready: got %b want 1", InReady);
        end
        @(negedge clk);
        scrambleIn();
        s = sampleObs();
        checks++;
        if (s !== eB || OutValid !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back_accept: got valid %b obs %h want valid 1 obs %h", OutValid, s, eB);
        end
        @(negedge clk);
        checks++;
        if (OutValid !== 1'b0) begin
            errors++; $display("FAIL back_to_back_retire: got valid %b want 0", OutValid);
        end
    endtask

    task automatic test_reset_busy();
        logic [105:0] allOut;
        txn_t v[$];
        @(negedge clk);
        driveIn(mk(0, 1, 0, 0, 1, 0, 5'd12, 32'h20, 32'hCAFEF00D, 32'h99));
        InValid = 1'b1;
        @(negedge clk);
        scrambleIn();
        rst_n = 1'b0;
        @(negedge clk);
        allOut = {OutValid, DatoMemOut, AluResOut, RegWriteOut, MemToRegOut, WriteRegOut,
                  PCSrcOut, BranchTargetOut, AlignErrOut};
        checks++;
        if (allOut !== '0 || InReady !== 1'b1) begin
            errors++; $display("FAIL reset_busy_outputs: got %h ready %b want 0 ready 1", allOut, InReady);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) refMem[i] = 32'd0;
        v.push_back(mk(1, 0, 0, 0, 1, 1, 5'd13, 32'h20, $urandom, 32'h0));
        runList("reset_busy_load", v);
    endtask

    task automatic test_random();
        txn_t v[$];
        txn_t t;
        int unsigned kind;
        logic [31:0] alu;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                alu = $urandom;
            end else begin
                alu = 32'($urandom_range(0, 15) << 2) + 32'($urandom_range(0, 3) << 8);
                if ($urandom_range(0, 4) == 0) alu = alu + 32'($urandom_range(1, 3));
            end
            t = mk(kind[0], kind[1], 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   5'($urandom), alu, $urandom, $urandom);
            v.push_back(t);
        end
        runList("random", v);
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_branch();
        test_misaligned();
        test_read_write_same();
        test_wrap();
        test_back_to_back();
        test_reset_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
